// File: rtl/jtldtest_pkg.sv
// Shared types and constants for the ldtest two-pass download verifier.
package jtldtest_pkg;

   // Read/compare FSM encoding
   typedef enum logic [1:0] {
      V_IDLE = 2'd0,
      V_REQ  = 2'd1,
      V_WAIT = 2'd2,
      V_CMP  = 2'd3
   } vstate_t;

   // Byte lane carried by even addresses in a 16-bit SDRAM word
   localparam bit SWAB_HI_EVEN = 1'b1;
   localparam bit SWAB_LO_EVEN = 1'b0;

   // Width of the SDRAM word address port
   localparam int unsigned RD_AW = 22;

   // Bank index width: at least one bit even for a single bank
   function automatic int unsigned calc_baw(input int unsigned banks);
      return (banks <= 2) ? 1 : $clog2(banks);
   endfunction

endpackage

// File: rtl/jtldtest_errlog.sv
// Per-pass error bookkeeping: saturating error count, first-failure log,
// sticky per-bank flags and the end-of-pass verdict.
module jtldtest_errlog
   import jtldtest_pkg::*;
#(
   parameter int unsigned AW    = 25,
   parameter int unsigned BANKS = 4,
   parameter int unsigned BAW   = 2,
   parameter int unsigned ERRW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             cmp_en,
   input  logic             mismatch,
   input  logic             end_pass,
   input  logic [BAW-1:0]   bank,
   input  logic [AW-1:0]    addr,
   input  logic [7:0]       exp_byte,
   input  logic [7:0]       got_byte,
   output logic [BANKS-1:0] bad_ba,
   output logic [ERRW-1:0]  err_cnt,
   output logic [AW-1:0]    first_addr,
   output logic [7:0]       first_exp,
   output logic [7:0]       first_got,
   output logic             pass_done,
   output logic             pass_ok
);

   logic compared;

   // Accumulate compare results; clear at the start of each verify pass
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bad_ba     <= '0;
         err_cnt    <= '0;
         first_addr <= '0;
         first_exp  <= '0;
         first_got  <= '0;
         compared   <= 1'b0;
         pass_done  <= 1'b0;
         pass_ok    <= 1'b0;
      end else begin
         pass_done <= end_pass;
         if (end_pass)
            pass_ok <= (err_cnt == '0) && compared;
         if (clr) begin
            bad_ba     <= '0;
            err_cnt    <= '0;
            first_addr <= '0;
            first_exp  <= '0;
            first_got  <= '0;
            compared   <= 1'b0;
            pass_ok    <= 1'b0;
         end else if (cmp_en) begin
            compared <= 1'b1;
            if (mismatch) begin
               bad_ba <= bad_ba | (BANKS'(1) << bank);
               if (err_cnt != '1)
                  err_cnt <= err_cnt + ERRW'(1);
               if (err_cnt == '0) begin
                  first_addr <= addr;
                  first_exp  <= exp_byte;
                  first_got  <= got_byte;
               end
            end
         end
      end
   end

endmodule

// File: rtl/jtldtest_verify.sv
// Two-pass SDRAM download verifier: first download is written by the
// external loader, the second is read back and compared byte by byte.
module jtldtest_verify
   import jtldtest_pkg::*;
#(
   parameter int unsigned AW     = 25,
   parameter int unsigned BANKS  = 4,
   parameter int unsigned BA_LSB = 23,
   parameter bit          SWAB   = 1'b1,
   parameter int unsigned ERRW   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             verify_only,
   input  logic             downloading,
   input  logic [AW-1:0]    ioctl_addr,
   input  logic [7:0]       ioctl_dout,
   input  logic             ioctl_wr,
   output logic             ioctl_wait,
   output logic             do_dwn,
   output logic             phase,
   output logic             refresh_en,
   output logic [BANKS-1:0] ba_rd,
   output logic [21:0]      rd_addr,
   input  logic [BANKS-1:0] ba_ack,
   input  logic [BANKS-1:0] ba_dst,
   input  logic [BANKS-1:0] ba_rdy,
   input  logic [15:0]      data_read,
   output logic [BANKS-1:0] bad_ba,
   output logic [ERRW-1:0]  err_cnt,
   output logic [AW-1:0]    first_addr,
   output logic [7:0]       first_exp,
   output logic [7:0]       first_got,
   output logic             pass_done,
   output logic             pass_ok,
   output logic             overrun
);

   localparam int unsigned BAW = calc_baw(BANKS);
   localparam int unsigned UW  = AW - BA_LSB;
   localparam int unsigned WW  = BA_LSB - 1;

   vstate_t          state, state_nx;
   logic             dl_q, wr_q;
   logic             dl_rise, dl_fall, wr_rise;
   logic             phase_eff, toggle_pend, toggle_evt, pass_end_evt, verify_start;
   logic [UW-1:0]    in_upper;
   logic [BAW-1:0]   in_bank;
   logic [WW-1:0]    in_word;
   logic [BANKS-1:0] in_sel, lat_sel;
   logic             in_range, accept, hit;
   logic [AW-1:0]    lat_addr;
   logic [7:0]       lat_dout;
   logic [BAW-1:0]   lat_bank;
   logic [15:0]      cache_data;
   logic [WW-1:0]    cache_word;
   logic [BAW-1:0]   cache_bank;
   logic             cache_vld;
   logic             lane_hi, mismatch;
   logic [7:0]       got_byte;
   logic [BANKS-1:0] ba_rd_nx;
   logic [21:0]      rd_addr_nx;
   logic             wait_nx;
   logic             unused_dst;

   // The data-strobe phase is not needed: ba_rdy already marks valid data
   assign unused_dst = ^ba_dst;

   // Edge detectors for the loader handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_q <= 1'b0;
         wr_q <= 1'b0;
      end else begin
         dl_q <= downloading;
         wr_q <= ioctl_wr;
      end
   end

   assign dl_rise = downloading & ~dl_q;
   assign dl_fall = ~downloading & dl_q;
   assign wr_rise = ioctl_wr & ~wr_q;

   assign phase_eff    = phase | verify_only;
   assign toggle_evt   = (dl_fall | toggle_pend) & (state == V_IDLE);
   assign pass_end_evt = toggle_evt & phase_eff;
   assign verify_start = dl_rise & phase_eff;
   assign do_dwn       = downloading & ~phase_eff;
   assign refresh_en   = ~downloading;

   // Pass phase; a download ending mid-compare defers the toggle to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase       <= 1'b0;
         toggle_pend <= 1'b0;
      end else begin
         if (toggle_evt)
            toggle_pend <= 1'b0;
         else if (dl_fall)
            toggle_pend <= 1'b1;
         if (verify_only)
            phase <= 1'b1;
         else if (toggle_evt)
            phase <= ~phase;
      end
   end

   // Incoming byte decode: bank, word address and cache lookup
   assign in_upper = ioctl_addr[AW-1:BA_LSB];
   assign in_range = 32'(in_upper) < BANKS;
   assign in_bank  = in_upper[BAW-1:0];
   assign in_word  = ioctl_addr[BA_LSB-1:1];
   assign in_sel   = BANKS'(1) << in_bank;
   assign lat_sel  = BANKS'(1) << lat_bank;
   assign accept   = wr_rise & downloading & phase_eff & in_range;
   assign hit      = cache_vld & (cache_word == in_word) & (cache_bank == in_bank);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= V_IDLE;
      else     state <= state_nx;
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         V_IDLE:  if (accept) state_nx = hit ? V_CMP : V_REQ;
         V_REQ:   if (|(ba_ack & lat_sel)) state_nx = V_WAIT;
         V_WAIT:  if (|(ba_rdy & lat_sel)) state_nx = V_CMP;
         V_CMP:   state_nx = V_IDLE;
         default: state_nx = V_IDLE;
      endcase
   end

   // FSM outputs, computed one cycle ahead so the ports come from flops
   always_comb begin
      ba_rd_nx   = '0;
      rd_addr_nx = rd_addr;
      wait_nx    = (state_nx != V_IDLE);
      if (state_nx == V_REQ)
         ba_rd_nx = (state == V_IDLE) ? in_sel : lat_sel;
      if ((state == V_IDLE) && (state_nx == V_REQ))
         rd_addr_nx = 22'(in_word);
   end

   // Output flops, latched request, one-word cache and overrun flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ba_rd      <= '0;
         rd_addr    <= '0;
         ioctl_wait <= 1'b0;
         lat_addr   <= '0;
         lat_dout   <= '0;
         lat_bank   <= '0;
         cache_data <= '0;
         cache_word <= '0;
         cache_bank <= '0;
         cache_vld  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         ba_rd      <= ba_rd_nx;
         rd_addr    <= rd_addr_nx;
         ioctl_wait <= wait_nx;
         if ((state == V_IDLE) && accept) begin
            lat_addr <= ioctl_addr;
            lat_dout <= ioctl_dout;
            lat_bank <= in_bank;
         end
         if ((state == V_WAIT) && |(ba_rdy & lat_sel)) begin
            cache_data <= data_read;
            cache_word <= lat_addr[BA_LSB-1:1];
            cache_bank <= lat_bank;
            cache_vld  <= 1'b1;
         end
         if (verify_start) begin
            cache_vld <= 1'b0;
            overrun   <= 1'b0;
         end else if (wr_rise & ioctl_wait) begin
            overrun <= 1'b1;
         end
      end
   end

   // Byte-lane select and compare against the latched loader byte
   assign lane_hi  = (SWAB == SWAB_HI_EVEN) ? ~lat_addr[0] : lat_addr[0];
   assign got_byte = lane_hi ? cache_data[15:8] : cache_data[7:0];
   assign mismatch = (got_byte != lat_dout);

   jtldtest_errlog #(
      .AW    (AW),
      .BANKS (BANKS),
      .BAW   (BAW),
      .ERRW  (ERRW)
   ) u_errlog (
      .clk        (clk),
      .rst        (rst),
      .clr        (verify_start),
      .cmp_en     (state == V_CMP),
      .mismatch   (mismatch),
      .end_pass   (pass_end_evt),
      .bank       (lat_bank),
      .addr       (lat_addr),
      .exp_byte   (lat_dout),
      .got_byte   (got_byte),
      .bad_ba     (bad_ba),
      .err_cnt    (err_cnt),
      .first_addr (first_addr),
      .first_exp  (first_exp),
      .first_got  (first_got),
      .pass_done  (pass_done),
      .pass_ok    (pass_ok)
   );

endmodule

// File: tb/tb_jtldtest_verify.sv
// Directed bench for jtldtest_verify: four-bank instance with an SDRAM
// responder model, plus a two-bank verify-only instance for bank range.
module tb_jtldtest_verify;

   localparam logic [24:0] NONE = 25'h1FFFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // Four-bank instance
   logic        verify_only = 1'b0;
   logic        downloading = 1'b0;
   logic [24:0] ioctl_addr  = '0;
   logic [7:0]  ioctl_dout  = '0;
   logic        ioctl_wr    = 1'b0;
   logic        ioctl_wait, do_dwn, phase, refresh_en;
   logic [3:0]  ba_rd, ba_ack, ba_dst, ba_rdy, bad_ba;
   logic [21:0] rd_addr;
   logic [15:0] data_read, err_cnt;
   logic [24:0] first_addr;
   logic [7:0]  first_exp, first_got;
   logic        pass_done, pass_ok, overrun;

   // Two-bank verify-only instance
   logic        dl2 = 1'b0;
   logic [24:0] addr2 = '0;
   logic [7:0]  dout2 = '0;
   logic        wr2 = 1'b0;
   logic        wait2, do_dwn2, phase2, refresh2, pass_done2, pass_ok2, overrun2;
   logic [1:0]  ba_rd2, bad_ba2;
   logic [21:0] rd_addr2;
   logic [15:0] err_cnt2;
   logic [24:0] first_addr2;
   logic [7:0]  first_exp2, first_got2;

   assign ba_dst = 4'b0;

   jtldtest_verify dut (
      .clk(clk), .rst(rst), .verify_only(verify_only), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
      .ioctl_wait(ioctl_wait), .do_dwn(do_dwn), .phase(phase), .refresh_en(refresh_en),
      .ba_rd(ba_rd), .rd_addr(rd_addr), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
      .data_read(data_read), .bad_ba(bad_ba), .err_cnt(err_cnt), .first_addr(first_addr),
      .first_exp(first_exp), .first_got(first_got), .pass_done(pass_done),
      .pass_ok(pass_ok), .overrun(overrun)
   );

   jtldtest_verify #(.BANKS(2)) dut2 (
      .clk(clk), .rst(rst), .verify_only(1'b1), .downloading(dl2),
      .ioctl_addr(addr2), .ioctl_dout(dout2), .ioctl_wr(wr2),
      .ioctl_wait(wait2), .do_dwn(do_dwn2), .phase(phase2), .refresh_en(refresh2),
      .ba_rd(ba_rd2), .rd_addr(rd_addr2), .ba_ack(2'b00), .ba_dst(2'b00), .ba_rdy(2'b00),
      .data_read(16'h0000), .bad_ba(bad_ba2), .err_cnt(err_cnt2), .first_addr(first_addr2),
      .first_exp(first_exp2), .first_got(first_got2), .pass_done(pass_done2),
      .pass_ok(pass_ok2), .overrun(overrun2)
   );

   // SDRAM contents as stored by the write pass (byte addressed)
   logic [7:0] bmem [int unsigned];

   function automatic logic [7:0] rdb(input int unsigned a);
      return bmem.exists(a) ? bmem[a] : 8'h00;
   endfunction

   function automatic int unsigned bidx(input logic [3:0] oh);
      int unsigned r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   // SDRAM controller model with programmable ack and ready latency
   int          ack_dly = 0;
   int          rdy_dly = 0;
   int          reads = 0;
   int          rs = 0;
   int          cnt = 0;
   logic [3:0]  req_ba = '0;
   int unsigned req_a = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rs        <= 0;
         cnt       <= 0;
         ba_ack    <= '0;
         ba_rdy    <= '0;
         data_read <= '0;
      end else begin
         ba_ack <= '0;
         ba_rdy <= '0;
         case (rs)
            0: if (|ba_rd) begin
                  rs     <= 1;
                  cnt    <= ack_dly;
                  req_ba <= ba_rd;
                  req_a  <= (bidx(ba_rd) << 23) | (32'(rd_addr) << 1);
                  reads  <= reads + 1;
               end
            1: if (cnt == 0) begin
                  ba_ack <= req_ba;
                  rs     <= 2;
                  cnt    <= rdy_dly;
               end else cnt <= cnt - 1;
            2: if (cnt == 0) begin
                  ba_rdy    <= req_ba;
                  data_read <= {rdb(req_a), rdb(req_a + 1)};
                  rs        <= 3;
               end else cnt <= cnt - 1;
            default: rs <= 0;
         endcase
      end
   end

   // Observation counters sampled away from the active edge
   int         pd_cnt = 0, pd2_cnt = 0, wait_cyc = 0, rd2_cyc = 0, wait2_cyc = 0;
   logic       pd_ok = 1'b0, pd2_ok = 1'b0;

   always @(negedge clk) begin
      if (pass_done)  begin pd_cnt  <= pd_cnt + 1;  pd_ok  <= pass_ok;  end
      if (pass_done2) begin pd2_cnt <= pd2_cnt + 1; pd2_ok <= pass_ok2; end
      if (ioctl_wait) wait_cyc  <= wait_cyc + 1;
      if (|ba_rd2)    rd2_cyc   <= rd2_cyc + 1;
      if (wait2)      wait2_cyc <= wait2_cyc + 1;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One loader byte; the bench plays the external writer when do_dwn is high
   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      int n = 0;
      ioctl_addr = a;
      ioctl_dout = d;
      if (do_dwn) bmem[32'(a)] = d;
      @(negedge clk); ioctl_wr = 1'b1;
      @(negedge clk); ioctl_wr = 1'b0;
      while (ioctl_wait && n < 200) begin @(negedge clk); n++; end
      check("wait_release", 32'(ioctl_wait), 0);
   endtask

   task automatic start_dl();
      @(negedge clk); downloading = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_dl(input int exp_pd, input logic exp_ok, input logic exp_phase);
      int p0 = pd_cnt;
      downloading = 1'b0;
      tick(3);
      check("pass_done_cnt", 32'(pd_cnt - p0), 32'(exp_pd));
      if (exp_pd != 0) check("pass_ok", 32'(pd_ok), 32'(exp_ok));
      check("phase_after", 32'(phase), 32'(exp_phase));
   endtask

   logic [24:0] addrs [20];
   logic [7:0]  vals  [20];

   task automatic wr_pass();
      int w0;
      int r0;
      start_dl();
      w0 = wait_cyc;
      r0 = reads;
      check("wpass_do_dwn", 32'(do_dwn), 1);
      check("wpass_refresh", 32'(refresh_en), 0);
      for (int i = 0; i < 20; i++) wr_byte(addrs[i], vals[i]);
      check("wpass_no_reads", 32'(reads - r0), 0);
      check("wpass_no_wait", 32'(wait_cyc - w0), 0);
      end_dl(0, 1'b0, 1'b1);
   endtask

   task automatic ver_pass(input logic [24:0] ma, input logic [7:0] va,
                           input logic [24:0] mb, input logic [7:0] vb);
      logic [7:0] d;
      int r0;
      start_dl();
      r0 = reads;
      check("vpass_do_dwn", 32'(do_dwn), 0);
      for (int i = 0; i < 20; i++) begin
         d = vals[i];
         if (addrs[i] == ma) d = va;
         if (addrs[i] == mb) d = vb;
         wr_byte(addrs[i], d);
         if (i == 15) check("reads_16_bytes", 32'(reads - r0), 8);
      end
      check("reads_all", 32'(reads - r0), 10);
   endtask

   initial begin
      int n;
      int r0;
      for (int i = 0; i < 16; i++) begin
         addrs[i] = 25'(i);
         vals[i]  = 8'(i);
      end
      addrs[16] = 25'h0800002; vals[16] = 8'h12;
      addrs[17] = 25'h0800003; vals[17] = 8'h34;
      addrs[18] = 25'h1800000; vals[18] = 8'h56;
      addrs[19] = 25'h1800001; vals[19] = 8'h78;

      // Reset values
      tick(2);
      check("rst_phase", 32'(phase), 0);
      check("rst_ba_rd", 32'(ba_rd), 0);
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_wait", 32'(ioctl_wait), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_bad_ba", 32'(bad_ba), 0);
      check("rst_first_addr", 32'(first_addr), 0);
      check("rst_pass_done", 32'(pass_done), 0);
      check("rst_pass_ok", 32'(pass_ok), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_refresh", 32'(refresh_en), 1);
      rst = 1'b0;
      tick(2);

      // Write pass then identical verify
      wr_pass();
      ver_pass(NONE, 8'h00, NONE, 8'h00);
      check("v1_err_cnt", 32'(err_cnt), 0);
      check("v1_bad_ba", 32'(bad_ba), 0);
      end_dl(1, 1'b1, 1'b0);

      // Single mismatch at byte 5
      wr_pass();
      ver_pass(25'h0000005, 8'hA5, NONE, 8'h00);
      check("v2_err_cnt", 32'(err_cnt), 1);
      check("v2_bad_ba", 32'(bad_ba), 32'h1);
      check("v2_first_addr", 32'(first_addr), 5);
      check("v2_first_exp", 32'(first_exp), 32'hA5);
      check("v2_first_got", 32'(first_got), 32'h05);
      end_dl(1, 1'b0, 1'b0);

      // Mismatches in banks 1 and 3
      wr_pass();
      ver_pass(25'h0800003, 8'hFF, 25'h1800001, 8'h00);
      check("v3_err_cnt", 32'(err_cnt), 2);
      check("v3_bad_ba", 32'(bad_ba), 32'hA);
      check("v3_first_addr", 32'(first_addr), 32'h0800003);
      check("v3_first_exp", 32'(first_exp), 32'hFF);
      check("v3_first_got", 32'(first_got), 32'h34);
      end_dl(1, 1'b0, 1'b0);

      // Slow ack with an overlapping loader write
      wr_pass();
      start_dl();
      check("ov_cleared", 32'(overrun), 0);
      ack_dly = 20;
      ioctl_addr = 25'h6; ioctl_dout = 8'h06;
      @(negedge clk); ioctl_wr = 1'b1;
      @(negedge clk); ioctl_wr = 1'b0;
      tick(3);
      check("ov_wait_held", 32'(ioctl_wait), 1);
      ioctl_addr = 25'h7; ioctl_dout = 8'h99;
      @(negedge clk); ioctl_wr = 1'b1;
      @(negedge clk); ioctl_wr = 1'b0;
      n = 0;
      while (ioctl_wait && n < 200) begin @(negedge clk); n++; end
      check("ov_wait_release", 32'(ioctl_wait), 0);
      check("ov_overrun", 32'(overrun), 1);
      check("ov_err_cnt", 32'(err_cnt), 0);
      check("ov_bad_ba", 32'(bad_ba), 0);
      ack_dly = 0;
      wr_byte(25'h7, 8'h07);
      check("ov_hit_err_cnt", 32'(err_cnt), 0);
      end_dl(1, 1'b1, 1'b0);

      // Reset while waiting for read data
      start_dl();
      end_dl(0, 1'b0, 1'b1);
      start_dl();
      wr_byte(25'h1, 8'hEE);
      check("rr_err_cnt", 32'(err_cnt), 1);
      check("rr_first_exp", 32'(first_exp), 32'hEE);
      rdy_dly = 10;
      ioctl_addr = 25'h0800002; ioctl_dout = 8'h12;
      @(negedge clk); ioctl_wr = 1'b1;
      @(negedge clk); ioctl_wr = 1'b0;
      n = 0;
      while (ba_rd == 4'b0 && n < 50) begin @(negedge clk); n++; end
      check("rr_ba_rd", 32'(ba_rd), 32'h2);
      check("rr_rd_addr", 32'(rd_addr), 1);
      while (ba_rd != 4'b0 && n < 50) begin @(negedge clk); n++; end
      check("rr_wait_state", 32'(ioctl_wait), 1);
      #2;
      rst = 1'b1;
      downloading = 1'b0;
      #1;
      check("rr_ba_rd_async", 32'(ba_rd), 0);
      check("rr_wait_async", 32'(ioctl_wait), 0);
      check("rr_rd_addr_async", 32'(rd_addr), 0);
      check("rr_phase_async", 32'(phase), 0);
      check("rr_err_cnt_async", 32'(err_cnt), 0);
      check("rr_bad_ba_async", 32'(bad_ba), 0);
      check("rr_first_addr_async", 32'(first_addr), 0);
      check("rr_first_exp_async", 32'(first_exp), 0);
      check("rr_first_got_async", 32'(first_got), 0);
      rdy_dly = 0;
      tick(2);
      rst = 1'b0;
      tick(2);
      start_dl();
      r0 = reads;
      check("rr_next_do_dwn", 32'(do_dwn), 1);
      wr_byte(25'h3, 8'h03);
      check("rr_next_no_reads", 32'(reads - r0), 0);
      end_dl(0, 1'b0, 1'b1);

      // Two-bank instance: out-of-range bank is ignored
      r0 = rd2_cyc;
      n = wait2_cyc;
      @(negedge clk); dl2 = 1'b1;
      tick(2);
      check("b2_phase", 32'(phase2), 1);
      addr2 = 25'h1000000; dout2 = 8'h55;
      @(negedge clk); wr2 = 1'b1;
      @(negedge clk); wr2 = 1'b0;
      tick(6);
      check("b2_no_read", 32'(rd2_cyc - r0), 0);
      check("b2_no_wait", 32'(wait2_cyc - n), 0);
      check("b2_err_cnt", 32'(err_cnt2), 0);
      check("b2_bad_ba", 32'(bad_ba2), 0);
      r0 = pd2_cnt;
      dl2 = 1'b0;
      tick(3);
      check("b2_pass_done", 32'(pd2_cnt - r0), 1);
      check("b2_pass_ok", 32'(pd2_ok), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtldtest_verify.md
# jtldtest_verify

Parametrised two-pass SDRAM download verifier for the ldtest core. The first ioctl download is written to SDRAM by the external downloader. The second download is read back byte by byte and compared against the incoming ioctl data. Unlike the fixed four-bank checker, it stalls the loader so that every byte is compared, caches one SDRAM word, and counts errors per pass. It also logs the first failure and reports a per-pass verdict.

## Interface
- AW, 25: ioctl address width.
- BANKS, 4: number of SDRAM banks checked (1..4). BAW = max(1, clog2(BANKS)).
- BA_LSB, 23: ioctl_addr[BA_LSB +: BAW] selects the bank; ioctl_addr[BA_LSB-1:1] is the word address.
- SWAB, 1: byte lane of even addresses. 1 selects data_read[15:8]; 0 selects data_read[7:0].
- ERRW, 16: error counter width.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- verify_only  in  1  when 1, every download is a verify pass (phase forced to 1).
- downloading  in  1  ioctl download active.
- ioctl_addr  in  AW  loader byte address.
- ioctl_dout  in  8  loader byte.
- ioctl_wr  in  1  loader write strobe; its rising edge qualifies a byte.
- ioctl_wait  out  1  stall request to the loader while a compare is pending.
- do_dwn  out  1  downloading & ~phase; enables the external writer.
- phase  out  1  0 = write pass, 1 = verify pass.
- refresh_en  out  1  ~downloading.
- ba_rd  out  BANKS  one-hot read request.
- rd_addr  out  22  word address, zero-extended.
- ba_ack, ba_dst, ba_rdy  in  BANKS  SDRAM controller handshake.
- data_read  in  16  SDRAM read data.
- bad_ba  out  BANKS  sticky per-bank mismatch flag for the current pass.
- err_cnt  out  ERRW  mismatches this pass; saturates at all ones.
- first_addr  out  AW  address of the first mismatch.
- first_exp, first_got  out  8  expected and read byte of the first mismatch.
- pass_done  out  1  one-cycle strobe at the end of a verify pass.
- pass_ok  out  1  valid at pass_done: err_cnt==0 and at least one byte compared.
- overrun  out  1  sticky: an ioctl_wr rising edge arrived while ioctl_wait was high.

## Operation
- Phase toggles when downloading falls and the FSM is in V_IDLE. If a compare is still in flight when downloading falls, the toggle is deferred until the FSM returns to V_IDLE.
- A rising edge of downloading with phase=1 starts a verify pass and clears the following: bad_ba, err_cnt, first_*, overrun, the compared flag and the cache-valid bit.
- The verify FSM states are V_IDLE, V_REQ, V_WAIT and V_CMP.
- V_IDLE: on an ioctl_wr rising edge with downloading=1 and phase=1, latch the address and byte and raise ioctl_wait.
  - If the bank index is >= BANKS, the byte is ignored and ioctl_wait stays low.
  - If the cache is valid and the cached word address and bank match, go to V_CMP.
  - Otherwise go to V_REQ.
- V_REQ: drive ba_rd[bank]=1 and rd_addr; hold both until ba_ack[bank], then go to V_WAIT with ba_rd low.
- V_WAIT: on ba_rdy[bank], store data_read into the cache, set the cache tag and valid bit, and go to V_CMP. ba_dst is not used for the transition.
- V_CMP: select the byte lane by ioctl_addr[0] and SWAB, then compare it with the latched byte.
  - On mismatch, set bad_ba[bank] and increment err_cnt (saturating).
  - If err_cnt was 0 before the increment, capture first_addr, first_exp and first_got.
  - Set the compared flag, drop ioctl_wait and return to V_IDLE.
- Address 0 is compared like any other byte.
- The write pass does not issue reads, and ioctl_wait stays 0 during it.
- pass_done pulses on the cycle phase toggles 1→0, or when downloading falls in verify_only mode.

## Timing
- Reset values:
  - phase=0 and FSM in V_IDLE.
  - ba_rd=0, rd_addr=0, ioctl_wait=0.
  - bad_ba=0, err_cnt=0, first_*=0.
  - pass_done=0, pass_ok=0, overrun=0, cache invalid.
- Cache hit: write edge seen at cycle 0, V_CMP at cycle 1, results visible and ioctl_wait low at cycle 2.
- Cache miss: ba_rd asserted at cycle 1. V_CMP follows one cycle after ba_rdy, and results appear one cycle after V_CMP.
- ioctl_wait is registered and rises in the cycle after the write edge. The loader must not issue a new write while it is high.
- An asynchronous reset mid-read drops ba_rd immediately. The SDRAM controller tolerates an abandoned request.

## Structure
- jtldtest_pkg holds the FSM state encoding, the SWAB lane-select constants and the BAW computation macro.
- Sub-module jtldtest_errlog contains err_cnt saturation, first-failure capture, bad_ba and pass_ok/pass_done. It takes mismatch, bank, address and bytes as inputs.
- The top level contains the edge detectors, the phase logic, the read FSM and the one-word cache.

## Test plan
- Write pass of 0x10 bytes (value = addr), then verify with identical data: 8 SDRAM reads (one per word), err_cnt=0 and pass_done with pass_ok=1.
- Verify with byte 0x0005 changed to 0xA5 (SDRAM holds 0x05): err_cnt=1, bad_ba=0001, first_addr=5, first_exp=0xA5, first_got=0x05.
- Mismatches at 0x0800003 and 0x1800001 with BANKS=4: bad_ba=1010, and first_addr=0x0800003.
- BANKS=2 with a write to 0x1000000: no read issued, ioctl_wait stays 0, err_cnt unchanged.
- ba_ack delayed 20 cycles with a second ioctl_wr issued while ioctl_wait=1: overrun=1. The first byte still compares correctly.
- Assert rst during V_WAIT: all outputs return to reset values on the same edge, phase=0, and the next download is a write pass.
